// File: rtl/cphy_rx_pkg.sv
// Shared C-PHY slave receive definitions: detector sequence codes and the
// HS receive burst controller state encoding.
package cphy_rx_pkg;

  localparam logic [3:0] SEQ_NONE = 4'b0000;
  localparam logic [3:0] SEQ_PRE  = 4'b0001;
  localparam logic [3:0] SEQ_SYNC = 4'b0010;
  localparam logic [3:0] SEQ_POST = 4'b0100;

  localparam int unsigned SYMS_PER_WORD_DEF = 7;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRE,
    WAIT_SYNC,
    DATA,
    DISCARD
  } hs_rx_state_t;

endpackage

// File: rtl/hs_word_aligner.sv
// Symbol-to-word alignment for the HS decoder: symbol index, pending word
// qualification, RxValidHS strobe and the saturating per-burst word count.
module hs_word_aligner
  import cphy_rx_pkg::*;
#(
  parameter int unsigned SYMS_PER_WORD = SYMS_PER_WORD_DEF,
  parameter int unsigned WCNT_W        = 16
) (
  input  logic              RxSymClkHs,
  input  logic              RstN,
  input  logic              burstStart,
  input  logic              syncStart,
  input  logic              symEn,
  input  logic              dropPend,
  output logic [2:0]        SymIdx,
  output logic              RxValidHS,
  output logic [WCNT_W-1:0] WordCnt
);

  localparam logic [2:0] SYM_LAST = 3'(SYMS_PER_WORD - 1);

  logic pendValid;

  always_ff @(posedge RxSymClkHs or negedge RstN) begin
    if (!RstN) begin
      SymIdx    <= '0;
      RxValidHS <= 1'b0;
      WordCnt   <= '0;
      pendValid <= 1'b0;
    end else begin
      RxValidHS <= 1'b0;
      // A completed word is only released once the following edge shows it
      // was not the start of a post or sync pattern.
      if (pendValid) begin
        pendValid <= 1'b0;
        if (!dropPend) begin
          RxValidHS <= 1'b1;
          if (WordCnt != '1)
            WordCnt <= WordCnt + 1'b1;
        end
      end
      if (burstStart) begin
        SymIdx    <= '0;
        WordCnt   <= '0;
        pendValid <= 1'b0;
      end else if (syncStart) begin
        SymIdx <= 3'd1;
      end else if (symEn) begin
        if (SymIdx == SYM_LAST) begin
          SymIdx    <= '0;
          pendValid <= 1'b1;
        end else begin
          SymIdx <= SymIdx + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/hs_rx_burst_ctrl.sv
// Per-lane HS receive burst controller: frames preamble/sync/data/post from
// the sequence detector and drives the PPI HS receive strobes and SoT flags.
module hs_rx_burst_ctrl
  import cphy_rx_pkg::*;
#(
  parameter int unsigned SYMS_PER_WORD = SYMS_PER_WORD_DEF,
  parameter int unsigned SYNC_TIMEOUT  = 64,
  parameter int unsigned WCNT_W        = 16
) (
  input  logic              RxSymClkHs,
  input  logic              RstN,
  input  logic              HsRxEn,
  input  logic [3:0]        DetectedSeq,
  input  logic              syncErr,
  input  logic              sotErr,
  output logic              DecEn,
  output logic [2:0]        SymIdx,
  output logic              RxActiveHS,
  output logic              RxSyncHS,
  output logic              RxValidHS,
  output logic [WCNT_W-1:0] WordCnt,
  output logic              BurstDone,
  output logic              ErrSotHS,
  output logic              ErrSotSyncHS
);

  localparam int unsigned     TO_W    = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYNC_TIMEOUT - 1);

  hs_rx_state_t    state;
  logic [TO_W-1:0] toCnt;

  logic isPre, isSync, isPost;
  logic burstStart, syncStart, decEnC, dropPend;

  assign isPre  = (DetectedSeq == SEQ_PRE);
  assign isSync = (DetectedSeq == SEQ_SYNC);
  assign isPost = (DetectedSeq == SEQ_POST);

  // The symbol sampled with an accepted sync is data symbol 0, so the decoder
  // is enabled and the aligner restarted on that same edge.
  always_comb begin
    burstStart = 1'b0;
    syncStart  = 1'b0;
    decEnC     = 1'b0;
    if (HsRxEn) begin
      case (state)
        WAIT_PRE:  burstStart = isPre;
        WAIT_SYNC: begin
          if (isSync && !syncErr) begin
            decEnC    = 1'b1;
            syncStart = 1'b1;
          end
        end
        DATA: begin
          if (!isPost && !(isSync && syncErr)) begin
            decEnC    = 1'b1;
            syncStart = isSync;
          end
        end
        default: ;
      endcase
    end
  end

  assign DecEn    = decEnC;
  assign dropPend = !HsRxEn || isPost || isSync;

  always_ff @(posedge RxSymClkHs or negedge RstN) begin
    if (!RstN) begin
      state        <= IDLE;
      toCnt        <= '0;
      RxActiveHS   <= 1'b0;
      RxSyncHS     <= 1'b0;
      BurstDone    <= 1'b0;
      ErrSotHS     <= 1'b0;
      ErrSotSyncHS <= 1'b0;
    end else begin
      RxSyncHS  <= 1'b0;
      BurstDone <= 1'b0;
      if (!HsRxEn) begin
        state      <= IDLE;
        RxActiveHS <= 1'b0;
      end else begin
        if (sotErr && (state inside {WAIT_SYNC, DATA, DISCARD}))
          ErrSotHS <= 1'b1;
        case (state)
          IDLE: state <= WAIT_PRE;
          WAIT_PRE: begin
            if (isPre) begin
              state        <= WAIT_SYNC;
              RxActiveHS   <= 1'b1;
              ErrSotHS     <= 1'b0;
              ErrSotSyncHS <= 1'b0;
              toCnt        <= '0;
            end
          end
          WAIT_SYNC: begin
            if (isSync) begin
              if (syncErr) begin
                state        <= DISCARD;
                ErrSotSyncHS <= 1'b1;
              end else begin
                state    <= DATA;
                RxSyncHS <= 1'b1;
              end
            end else if (isPre) begin
              toCnt <= '0;
            end else if (toCnt == TO_LAST) begin
              state        <= DISCARD;
              ErrSotSyncHS <= 1'b1;
            end else begin
              toCnt <= toCnt + 1'b1;
            end
          end
          DATA: begin
            if (isPost) begin
              state      <= WAIT_PRE;
              RxActiveHS <= 1'b0;
              BurstDone  <= 1'b1;
            end else if (isSync) begin
              if (syncErr) begin
                state        <= DISCARD;
                ErrSotSyncHS <= 1'b1;
              end else begin
                RxSyncHS <= 1'b1;
              end
            end
          end
          DISCARD: begin
            if (isPost) begin
              state      <= WAIT_PRE;
              RxActiveHS <= 1'b0;
              BurstDone  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  hs_word_aligner #(
    .SYMS_PER_WORD(SYMS_PER_WORD),
    .WCNT_W       (WCNT_W)
  ) u_aligner (
    .RxSymClkHs(RxSymClkHs),
    .RstN      (RstN),
    .burstStart(burstStart),
    .syncStart (syncStart),
    .symEn     (decEnC),
    .dropPend  (dropPend),
    .SymIdx    (SymIdx),
    .RxValidHS (RxValidHS),
    .WordCnt   (WordCnt)
  );

endmodule

// File: tb/tb_hs_rx_burst_ctrl.sv
// Directed bench for hs_rx_burst_ctrl; strobe outputs are checked against
// expected-event queues filled by the stimulus, status outputs directly.
module tb_hs_rx_burst_ctrl;
  import cphy_rx_pkg::*;

  logic        RxSymClkHs = 1'b0;
  logic        RstN       = 1'b0;
  logic        HsRxEn     = 1'b0;
  logic [3:0]  DetectedSeq = SEQ_NONE;
  logic        syncErr    = 1'b0;
  logic        sotErr     = 1'b0;
  logic        DecEn;
  logic [2:0]  SymIdx;
  logic        RxActiveHS;
  logic        RxSyncHS;
  logic        RxValidHS;
  logic [15:0] WordCnt;
  logic        BurstDone;
  logic        ErrSotHS;
  logic        ErrSotSyncHS;

  hs_rx_burst_ctrl #(
    .SYMS_PER_WORD(7),
    .SYNC_TIMEOUT (8),
    .WCNT_W       (16)
  ) dut (
    .RxSymClkHs  (RxSymClkHs),
    .RstN        (RstN),
    .HsRxEn      (HsRxEn),
    .DetectedSeq (DetectedSeq),
    .syncErr     (syncErr),
    .sotErr      (sotErr),
    .DecEn       (DecEn),
    .SymIdx      (SymIdx),
    .RxActiveHS  (RxActiveHS),
    .RxSyncHS    (RxSyncHS),
    .RxValidHS   (RxValidHS),
    .WordCnt     (WordCnt),
    .BurstDone   (BurstDone),
    .ErrSotHS    (ErrSotHS),
    .ErrSotSyncHS(ErrSotSyncHS)
  );

  always #5 RxSymClkHs = ~RxSymClkHs;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t expValidQ[$];
  exp_t expSyncQ[$];
  exp_t expDoneQ[$];

  int nChecks  = 0;
  int nFails   = 0;
  int cyc      = 0;
  int decEnCnt = 0;
  int decSnap  = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string nm);
    nChecks++;
    nFails++;
    $display("FAIL %s: got a pulse, expected none (cycle %0d)", nm, cyc);
  endfunction

  initial forever begin
    @(posedge RxSymClkHs);
    cyc++;
  end

  // Monitor: consumes one expected entry per output strobe.
  initial forever begin
    exp_t e;
    @(negedge RxSymClkHs);
    if (DecEn) decEnCnt++;
    if (RxValidHS) begin
      if (expValidQ.size() == 0) unexpected("valid_unexpected");
      else begin
        e = expValidQ.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("valid_wordcnt", int'(WordCnt), e.val);
      end
    end
    if (RxSyncHS) begin
      if (expSyncQ.size() == 0) unexpected("sync_unexpected");
      else begin
        e = expSyncQ.pop_front();
        chk("sync_cycle", cyc, e.cyc);
        chk("sync_symidx", int'(SymIdx), e.val);
      end
    end
    if (BurstDone) begin
      if (expDoneQ.size() == 0) unexpected("done_unexpected");
      else begin
        e = expDoneQ.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_active", int'(RxActiveHS), e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [3:0] s, input logic se = 1'b0, input logic so = 1'b0);
    DetectedSeq = s;
    syncErr     = se;
    sotErr      = so;
    @(posedge RxSymClkHs);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(SEQ_NONE);
  endtask

  task automatic pushValid(input int dly, input int wc);
    exp_t e;
    e.cyc = cyc + dly;
    e.val = wc;
    expValidQ.push_back(e);
  endtask

  task automatic pushSync(input int dly);
    exp_t e;
    e.cyc = cyc + dly;
    e.val = 1;
    expSyncQ.push_back(e);
  endtask

  task automatic pushDone(input int dly);
    exp_t e;
    e.cyc = cyc + dly;
    e.val = 0;
    expDoneQ.push_back(e);
  endtask

  task automatic drained(input string nm);
    chk({nm, "_valid_missing"}, expValidQ.size(), 0);
    chk({nm, "_sync_missing"}, expSyncQ.size(), 0);
    chk({nm, "_done_missing"}, expDoneQ.size(), 0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge RxSymClkHs);
    #1;
    chk("rst_outputs", int'({DecEn, SymIdx, RxActiveHS, RxSyncHS, RxValidHS,
                             WordCnt, BurstDone, ErrSotHS, ErrSotSyncHS}), 0);
    RstN   = 1'b1;
    HsRxEn = 1'b1;
    idle(1);
    chk("wait_pre_inactive", int'(RxActiveHS), 0);

    // clean burst
    drive(SEQ_PRE);
    chk("clean_active_after_pre", int'(RxActiveHS), 1);
    decSnap = decEnCnt;
    pushSync(1);
    drive(SEQ_SYNC);
    pushValid(7, 1);
    idle(7);
    pushDone(1);
    drive(SEQ_POST);
    idle(2);
    chk("clean_wordcnt", int'(WordCnt), 1);
    chk("clean_errs", int'({ErrSotHS, ErrSotSyncHS}), 0);
    chk("clean_decen_count", decEnCnt - decSnap, 8);
    drained("clean");

    // bad sync word
    drive(SEQ_PRE);
    decSnap = decEnCnt;
    drive(SEQ_SYNC, 1'b1);
    chk("badsync_err", int'(ErrSotSyncHS), 1);
    chk("badsync_active", int'(RxActiveHS), 1);
    idle(6);
    pushDone(1);
    drive(SEQ_POST);
    chk("badsync_inactive", int'(RxActiveHS), 0);
    chk("badsync_decen_count", decEnCnt - decSnap, 0);
    idle(2);
    drained("badsync");

    // two syncs in one burst; sync word itself not counted
    drive(SEQ_PRE);
    chk("dsync_err_cleared", int'(ErrSotSyncHS), 0);
    decSnap = decEnCnt;
    pushSync(1);
    drive(SEQ_SYNC);
    pushValid(7, 1);
    idle(7);
    pushSync(1);
    drive(SEQ_SYNC);
    pushValid(7, 2);
    idle(7);
    pushDone(1);
    drive(SEQ_POST);
    idle(2);
    chk("dsync_wordcnt", int'(WordCnt), 2);
    chk("dsync_syncerr", int'(ErrSotSyncHS), 0);
    chk("dsync_decen_count", decEnCnt - decSnap, 16);
    drained("dsync");

    // completed word dropped by a following sync, then by a following post
    drive(SEQ_PRE);
    pushSync(1);
    drive(SEQ_SYNC);
    idle(6);
    chk("drop_symidx_wrap", int'(SymIdx), 0);
    pushSync(1);
    drive(SEQ_SYNC);
    pushValid(7, 1);
    idle(7);
    idle(6);
    pushDone(1);
    drive(SEQ_POST);
    idle(2);
    chk("drop_wordcnt", int'(WordCnt), 1);
    drained("drop");

    // sync timeout, counter restarted by a repeated preamble
    drive(SEQ_PRE);
    decSnap = decEnCnt;
    idle(5);
    drive(SEQ_PRE);
    idle(7);
    chk("timeout_not_yet", int'(ErrSotSyncHS), 0);
    idle(1);
    chk("timeout_err", int'(ErrSotSyncHS), 1);
    chk("timeout_active", int'(RxActiveHS), 1);
    drive(SEQ_NONE, 1'b0, 1'b1);
    chk("discard_soterr", int'(ErrSotHS), 1);
    pushDone(1);
    drive(SEQ_POST);
    chk("timeout_inactive", int'(RxActiveHS), 0);
    chk("timeout_decen_count", decEnCnt - decSnap, 0);
    idle(2);
    drained("timeout");

    // HsRxEn dropped with SymIdx = 6
    drive(SEQ_PRE);
    chk("en_soterr_cleared", int'(ErrSotHS), 0);
    decSnap = decEnCnt;
    pushSync(1);
    drive(SEQ_SYNC);
    pushValid(7, 1);
    idle(7);
    drive(SEQ_NONE, 1'b0, 1'b1);
    idle(4);
    chk("en_symidx_before", int'(SymIdx), 6);
    HsRxEn = 1'b0;
    drive(SEQ_NONE);
    chk("en_inactive", int'(RxActiveHS), 0);
    idle(3);
    chk("en_soterr_hold", int'(ErrSotHS), 1);
    chk("en_wordcnt_hold", int'(WordCnt), 1);
    chk("en_decen_count", decEnCnt - decSnap, 13);
    drained("en");
    HsRxEn = 1'b1;
    idle(1);
    drive(SEQ_PRE);
    chk("reen_clears", int'({ErrSotHS, ErrSotSyncHS, WordCnt}), 0);
    chk("reen_active", int'(RxActiveHS), 1);

    // asynchronous reset mid-DATA
    pushSync(1);
    drive(SEQ_SYNC);
    pushValid(7, 1);
    idle(7);
    drive(SEQ_NONE, 1'b0, 1'b1);
    idle(1);
    chk("arst_pre_state", int'({RxActiveHS, ErrSotHS, WordCnt}), 32'h30001);
    drained("arst_pre");
    #3;
    RstN = 1'b0;
    #1;
    chk("arst_outputs", int'({DecEn, SymIdx, RxActiveHS, RxSyncHS, RxValidHS,
                              WordCnt, BurstDone, ErrSotHS, ErrSotSyncHS}), 0);
    #2;
    RstN = 1'b1;
    @(posedge RxSymClkHs);
    #1;
    chk("arst_idle_inactive", int'(RxActiveHS), 0);
    drive(SEQ_PRE);
    chk("arst_burst_restart", int'(RxActiveHS), 1);
    idle(2);
    drained("final");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/hs_rx_burst_ctrl.md
Name: hs_rx_burst_ctrl

Overview:
- Per-lane HS receive burst controller in the C-PHY slave, clocked by the recovered symbol clock.
- Consumes Sequence_Detector outputs (DetectedSeq, syncErr, sotErr) and sequences the HS receive path:
  - burst framing: preamble, then sync, then data, then post;
  - 7-symbol word alignment for the symbol decoder;
  - PPI-style RxActiveHS/RxSyncHS/RxValidHS strobes and SoT error flags.
- Sits between Sequence_Detector and the symbol-to-word decoder.

Parameters:
- SYMS_PER_WORD, 7: symbols per 16-bit word.
- SYNC_TIMEOUT, 64: cycles allowed in WAIT_SYNC without preamble or sync before a SoT sync error.
- WCNT_W, 16: width of the word counter.

Ports:
- RxSymClkHs  in  1  symbol clock; all logic on posedge.
- RstN  in  1  reset, asynchronous assert, active-low.
- HsRxEn  in  1  lane FSM permits HS reception.
- DetectedSeq  in  4  one-hot detector code; codes defined in the package.
- syncErr  in  1  qualifies SEQ_SYNC: sync word malformed.
- sotErr  in  1  detector SoT error.
- DecEn  out  1  decoder consumes the RxSymbol sampled at this edge (combinational).
- SymIdx  out  3  index 0..SYMS_PER_WORD-1 of the next data symbol.
- RxActiveHS  out  1  burst in progress.
- RxSyncHS  out  1  one-cycle pulse per accepted sync word.
- RxValidHS  out  1  one-cycle pulse, decoder word valid.
- WordCnt  out  WCNT_W  words delivered this burst; saturates at max.
- BurstDone  out  1  one-cycle pulse at end of burst.
- ErrSotHS  out  1  sticky.
- ErrSotSyncHS  out  1  sticky.

Behaviour:
- Reset values:
  - state = IDLE;
  - all outputs 0;
  - SymIdx = 0, WordCnt = 0;
  - pending-valid flag = 0, timeout counter = 0.
- States: IDLE, WAIT_PRE, WAIT_SYNC, DATA, DISCARD.
- Any state, HsRxEn = 0 at an edge:
  - next state IDLE;
  - RxActiveHS = 0;
  - pending valid dropped;
  - no BurstDone;
  - error flags hold.
- IDLE: HsRxEn = 1 → WAIT_PRE.
- WAIT_PRE: DetectedSeq == SEQ_PRE →
  - WAIT_SYNC;
  - RxActiveHS = 1;
  - WordCnt, ErrSotHS, ErrSotSyncHS and the timeout counter cleared.
- WAIT_SYNC, timeout counter:
  - counts every cycle;
  - cleared whenever SEQ_PRE is seen.
- WAIT_SYNC, exits:
  - SEQ_SYNC with syncErr = 0 → DATA. DecEn = 1 combinationally at that edge, and that edge's symbol is data symbol 0. SymIdx becomes 1 and RxSyncHS pulses in the next cycle.
  - SEQ_SYNC with syncErr = 1 → DISCARD; ErrSotSyncHS = 1.
  - Counter reaches SYNC_TIMEOUT → DISCARD; ErrSotSyncHS = 1.
- DATA, symbol counting:
  - DecEn = 1 on every edge;
  - SymIdx increments modulo SYMS_PER_WORD.
- DATA, word completion and pending valid:
  - The edge consuming SymIdx = 6 completes a word and sets the pending-valid flag.
  - At the next edge, if DetectedSeq is SEQ_POST or SEQ_SYNC, pending is dropped (the word was the post or sync pattern).
  - Otherwise RxValidHS pulses in the following cycle and WordCnt increments.
  - Latency: 2 edges from the last symbol of the word to RxValidHS high.
- DATA, sequence events:
  - Mid-burst SEQ_SYNC with syncErr = 0: pending dropped; that edge's symbol is symbol 0 (SymIdx becomes 1); RxSyncHS pulses. State stays DATA.
  - Mid-burst SEQ_SYNC with syncErr = 1: ErrSotSyncHS = 1; → DISCARD.
  - SEQ_POST → BurstDone pulse next cycle; RxActiveHS = 0; DecEn = 0; state → WAIT_PRE.
- DISCARD:
  - DecEn = 0; no RxValidHS; RxActiveHS stays 1.
  - SEQ_POST → BurstDone pulse; → WAIT_PRE.
- sotErr = 1 in WAIT_SYNC, DATA or DISCARD sets ErrSotHS.
- Simultaneous-event priority, highest first:
  1. HsRxEn = 0
  2. SEQ_POST
  3. SEQ_SYNC
  4. timeout
  5. word completion
- DetectedSeq equal to 0 or any undefined code: no sequence event.
- WordCnt saturates at all-ones.

Decomposition:
- Package cphy_rx_pkg holds:
  - SEQ_NONE = 4'b0000, SEQ_PRE = 4'b0001, SEQ_SYNC = 4'b0010, SEQ_POST = 4'b0100;
  - hs_rx_state_t enum;
  - SYMS_PER_WORD default.
- One natural sub-module: hs_word_aligner. It holds the SymIdx counter, the pending-valid flag, RxValidHS and WordCnt, controlled by the main FSM through start/restart/drop/enable.

Test Plan:
- Clean burst: HsRxEn = 1; 7×sym 3; 3,4,4,4,4,4,3; 7 data symbols; 7×sym 4 → RxActiveHS rises one cycle after PRE; RxSyncHS one pulse; RxValidHS exactly 1 pulse; WordCnt = 1; BurstDone one pulse; both errors 0.
- Bad sync: preamble then 3,4,4,4,3 with syncErr = 1 → ErrSotSyncHS = 1; state DISCARD; no RxValidHS; after 7×sym 4, BurstDone pulses and RxActiveHS = 0.
- Double sync mid-burst: PRE, SYNC, 7 data, SYNC, 7 data, POST → RxSyncHS 2 pulses; RxValidHS 2 pulses (sync pattern not counted); WordCnt = 2; ErrSotSyncHS = 0.
- Sync timeout, SYNC_TIMEOUT = 8: preamble then 10 cycles with DetectedSeq = 0 → ErrSotSyncHS rises on the 8th cycle; DecEn never 1.
- HsRxEn dropped mid-DATA at SymIdx = 6: → next cycle state IDLE; RxValidHS stays 0; no BurstDone. Re-enable plus a new preamble clears the error flags and WordCnt.
- Async reset mid-DATA: RstN low between edges → all outputs 0 immediately; state IDLE after release.
